i2c_bus_router: RTL and testbench

- Routes one I2C host controller (open-drain scl/sda drive + enable, line readback) onto one of several physical I2C buses (J1, J7 QWIIC, RPi HAT, HAT ID EEPROM, mikroBUS).
- Run-time selection by software, replacing build-time bus selection.
- Switches only while the selected bus is idle, with a guaranteed all-released settle gap, so no bus ever sees a truncated transaction or a glitch.
- Sits between the I2C host and the top-level open-drain pad drivers.

---
 rtl/i2c_router_pkg.sv | 36 +++
 rtl/i2c_bus_monitor.sv | 65 ++++++
 rtl/i2c_bus_router.sv | 197 +++++++++++++++++++
 tb/tb_i2c_bus_router.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_router_pkg.sv
// Shared definitions for the I2C bus router: FSM state encoding and bus-condition
// codes, plus the START/STOP classifier used by the bus monitor.
package i2c_router_pkg;

    typedef logic [1:0] router_state_t;

    localparam router_state_t ST_CONNECTED = 2'd0;
    localparam router_state_t ST_DRAIN     = 2'd1;
    localparam router_state_t ST_SETTLE    = 2'd2;

    typedef logic [1:0] bus_cond_t;

    localparam bus_cond_t COND_NONE  = 2'd0;
    localparam bus_cond_t COND_START = 2'd1;
    localparam bus_cond_t COND_STOP  = 2'd2;

    // SDA may only change while SCL is high at a START or STOP.
    function automatic bus_cond_t bus_cond(
        input logic scl_prev,
        input logic sda_prev,
        input logic scl,
        input logic sda
    );
        bus_cond_t cond;
        cond = COND_NONE;
        if (scl_prev && scl) begin
            if (sda_prev && !sda) begin
                cond = COND_START;
            end else if (!sda_prev && sda) begin
                cond = COND_STOP;
            end
        end
        return cond;
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Tracks whether the selected I2C bus is inside a transaction, from synchronised
// line samples: START sets busy, STOP or a long all-high quiet period clears it.
module i2c_bus_monitor
    import i2c_router_pkg::*;
#(
    parameter int IdleCycles = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic scl_i,
    input  logic sda_i,
    input  logic hostlow_i,
    output logic busy_o
);

    localparam int IdleW = $clog2(IdleCycles + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleCycles);

    logic             scl_prev_q, scl_prev_d;
    logic             sda_prev_q, sda_prev_d;
    logic             busy_q, busy_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    bus_cond_t        cond;
    logic             quiet;

    always_comb begin
        cond       = bus_cond(scl_prev_q, sda_prev_q, scl_i, sda_i);
        quiet      = scl_i && sda_i && !hostlow_i;
        scl_prev_d = scl_i;
        sda_prev_d = sda_i;

        idle_cnt_d = '0;
        if (quiet && !clr_i) begin
            idle_cnt_d = (idle_cnt_q == IdleMax) ? idle_cnt_q : idle_cnt_q + IdleW'(1);
        end

        // A missing STOP (host reset, aborted master) must not pin the bus busy forever.
        busy_d = busy_q;
        if (clr_i) begin
            busy_d = 1'b0;
        end else if (cond == COND_START) begin
            busy_d = 1'b1;
        end else if (cond == COND_STOP || idle_cnt_d == IdleMax) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            busy_q     <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            busy_q     <= busy_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/i2c_bus_router.sv
// Run-time router of one I2C host onto one of NumPorts physical buses; switches only
// when the bus is idle, with an all-released settle gap. Optional: I2C_ROUTER_MIRROR_EN.
module i2c_bus_router
    import i2c_router_pkg::*;
#(
    parameter int NumPorts     = 4,
    parameter int PortW        = $clog2(NumPorts),
    parameter int DefaultPort  = 0,
    parameter int IdleCycles   = 1000,
    parameter int SettleCycles = 16
) (
    input  logic                clk_sys_i,
    input  logic                rst_sys_i,
    input  logic                sel_valid_i,
    input  logic [PortW-1:0]    sel_port_i,
    output logic                sel_ready_o,
    output logic                sel_err_o,
    output logic [PortW-1:0]    cur_port_o,
    output logic                switching_o,
    output logic                bus_busy_o,
`ifdef I2C_ROUTER_MIRROR_EN
    output logic                mirror_scl_o,
    output logic                mirror_sda_o,
`endif
    input  logic                ctl_scl_i,
    input  logic                ctl_sda_i,
    input  logic                ctl_scl_en_i,
    input  logic                ctl_sda_en_i,
    output logic                ctl_scl_o,
    output logic                ctl_sda_o,
    input  logic [NumPorts-1:0] port_scl_i,
    input  logic [NumPorts-1:0] port_sda_i,
    output logic [NumPorts-1:0] port_scl_o,
    output logic [NumPorts-1:0] port_sda_o,
    output logic [NumPorts-1:0] port_scl_en_o,
    output logic [NumPorts-1:0] port_sda_en_o
);

    // Handshake: a request transfers on a clock edge where sel_valid_i && sel_ready_o;
    // sel_port_i is sampled only then, and sel_ready_o is high only while CONNECTED.

    localparam int SetW = $clog2(SettleCycles + 1);
    localparam logic [PortW:0]   PortLimit   = (PortW + 1)'(NumPorts);
    localparam logic [PortW-1:0] PortDefault = PortW'(DefaultPort);
    localparam logic [SetW-1:0]  SettleLoad  = SetW'(SettleCycles - 1);

    logic [NumPorts-1:0] scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d;
    logic [NumPorts-1:0] sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d;
    router_state_t       state_q, state_d;
    logic [PortW-1:0]    cur_port_q, cur_port_d;
    logic [PortW-1:0]    target_q, target_d;
    logic [SetW-1:0]     settle_cnt_q, settle_cnt_d;
    logic                armed_q, armed_d;
    logic                err_q, err_d;

    logic hostlow;
    logic sel_scl, sel_sda;
    logic transfer;
    logic drain_done;
    logic in_settle;
    logic busy;

    assign hostlow    = (ctl_scl_en_i && !ctl_scl_i) || (ctl_sda_en_i && !ctl_sda_i);
    assign sel_scl    = scl_s2_q[cur_port_q];
    assign sel_sda    = sda_s2_q[cur_port_q];
    assign in_settle  = (state_q == ST_SETTLE);
    assign transfer   = sel_valid_i && sel_ready_o;
    // One DRAIN cycle of dwell lets the monitor see the latest sample before release.
    assign drain_done = (state_q == ST_DRAIN) && armed_q && !busy && !hostlow;

    i2c_bus_monitor #(
        .IdleCycles(IdleCycles)
    ) u_monitor (
        .clk_i    (clk_sys_i),
        .rst_i    (rst_sys_i),
        .clr_i    (drain_done),
        .scl_i    (sel_scl),
        .sda_i    (sda_s2_q[cur_port_q]),
        .hostlow_i(hostlow),
        .busy_o   (busy)
    );

    always_comb begin
        scl_s1_d = port_scl_i;
        sda_s1_d = port_sda_i;
        scl_s2_d = scl_s1_q;
        sda_s2_d = sda_s1_q;

        state_d      = state_q;
        cur_port_d   = cur_port_q;
        target_d     = target_q;
        settle_cnt_d = settle_cnt_q;
        armed_d      = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_CONNECTED: begin
                if (transfer) begin
                    if ({1'b0, sel_port_i} >= PortLimit) begin
                        err_d = 1'b1;
                    end else if (sel_port_i != cur_port_q) begin
                        target_d = sel_port_i;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                armed_d = 1'b1;
                if (drain_done) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SettleLoad;
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    cur_port_d = target_q;
                    state_d    = ST_CONNECTED;
                end else begin
                    settle_cnt_d = settle_cnt_q - SetW'(1);
                end
            end
            default: begin
                state_d = ST_CONNECTED;
            end
        endcase
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            scl_s1_q     <= '1;
            scl_s2_q     <= '1;
            sda_s1_q     <= '1;
            sda_s2_q     <= '1;
            state_q      <= ST_CONNECTED;
            cur_port_q   <= PortDefault;
            target_q     <= PortDefault;
            settle_cnt_q <= '0;
            armed_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            scl_s1_q     <= scl_s1_d;
            scl_s2_q     <= scl_s2_d;
            sda_s1_q     <= sda_s1_d;
            sda_s2_q     <= sda_s2_d;
            state_q      <= state_d;
            cur_port_q   <= cur_port_d;
            target_q     <= target_d;
            settle_cnt_q <= settle_cnt_d;
            armed_q      <= armed_d;
            err_q        <= err_d;
        end
    end

    // Pads are driven with zero latency so the host's own timing reaches the bus intact.
    always_comb begin
        port_scl_en_o = '0;
        port_sda_en_o = '0;
        for (int i = 0; i < NumPorts; i++) begin
            port_scl_en_o[i] = ctl_scl_en_i && (PortW'(i) == cur_port_q) && !in_settle;
            port_sda_en_o[i] = ctl_sda_en_i && (PortW'(i) == cur_port_q) && !in_settle;
        end
    end

    assign port_scl_o  = {NumPorts{ctl_scl_i}};
    assign port_sda_o  = {NumPorts{ctl_sda_i}};
    assign ctl_scl_o   = in_settle ? 1'b1 : sel_scl;
    assign ctl_sda_o   = in_settle ? 1'b1 : sel_sda;
    assign sel_ready_o = (state_q == ST_CONNECTED);
    assign sel_err_o   = err_q;
    assign cur_port_o  = cur_port_q;
    assign switching_o = (state_q != ST_CONNECTED);
    assign bus_busy_o  = busy;

`ifdef I2C_ROUTER_MIRROR_EN
    logic mirror_scl_q, mirror_scl_d;
    logic mirror_sda_q, mirror_sda_d;

    always_comb begin
        mirror_scl_d = (state_d == ST_SETTLE) ? 1'b1 : sel_scl;
        mirror_sda_d = (state_d == ST_SETTLE) ? 1'b1 : sel_sda;
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            mirror_scl_q <= 1'b1;
            mirror_sda_q <= 1'b1;
        end else begin
            mirror_scl_q <= mirror_scl_d;
            mirror_sda_q <= mirror_sda_d;
        end
    end

    assign mirror_scl_o = mirror_scl_q;
    assign mirror_sda_o = mirror_sda_q;
`endif

endmodule

// File: tb/tb_i2c_bus_router.sv
// Directed bench for i2c_bus_router: five buses, open-drain pads looped back,
// hand-computed latencies for switch, drain, idle timeout and reset.
module tb_i2c_bus_router;

    localparam int NP     = 5;
    localparam int PW     = $clog2(NP);
    localparam int IDLE   = 1000;
    localparam int SETTLE = 16;

    logic          clk_sys;
    logic          rst_sys;
    logic          sel_valid;
    logic [PW-1:0] sel_port;
    logic          sel_ready;
    logic          sel_err;
    logic [PW-1:0] cur_port;
    logic          switching;
    logic          bus_busy;
    logic          ctl_scl, ctl_sda, ctl_scl_en, ctl_sda_en;
    logic          ctl_scl_rb, ctl_sda_rb;
    logic [NP-1:0] port_scl_in, port_sda_in;
    logic [NP-1:0] port_scl_out, port_sda_out;
    logic [NP-1:0] port_scl_en, port_sda_en;
`ifdef I2C_ROUTER_MIRROR_EN
    logic          mirror_scl, mirror_sda;
`endif

    int n_checks;
    int n_pass;

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Open-drain pads with pull-ups: a line is low only while someone drives 0.
    assign port_scl_in = ~(port_scl_en & ~port_scl_out);
    assign port_sda_in = ~(port_sda_en & ~port_sda_out);

    i2c_bus_router #(
        .NumPorts    (NP),
        .DefaultPort (0),
        .IdleCycles  (IDLE),
        .SettleCycles(SETTLE)
    ) dut (
        .clk_sys_i    (clk_sys),
        .rst_sys_i    (rst_sys),
        .sel_valid_i  (sel_valid),
        .sel_port_i   (sel_port),
        .sel_ready_o  (sel_ready),
        .sel_err_o    (sel_err),
        .cur_port_o   (cur_port),
        .switching_o  (switching),
        .bus_busy_o   (bus_busy),
`ifdef I2C_ROUTER_MIRROR_EN
        .mirror_scl_o (mirror_scl),
        .mirror_sda_o (mirror_sda),
`endif
        .ctl_scl_i    (ctl_scl),
        .ctl_sda_i    (ctl_sda),
        .ctl_scl_en_i (ctl_scl_en),
        .ctl_sda_en_i (ctl_sda_en),
        .ctl_scl_o    (ctl_scl_rb),
        .ctl_sda_o    (ctl_sda_rb),
        .port_scl_i   (port_scl_in),
        .port_sda_i   (port_sda_in),
        .port_scl_o   (port_scl_out),
        .port_sda_o   (port_sda_out),
        .port_scl_en_o(port_scl_en),
        .port_sda_en_o(port_sda_en)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Every drive and sample happens 2 time units after a rising edge.
    task automatic step();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic request(input logic [PW-1:0] p);
        sel_valid = 1'b1;
        sel_port  = p;
        step();
        sel_valid = 1'b0;
    endtask

    task automatic wait_ready(input int max_steps, output int n);
        n = 0;
        while (!sel_ready && n < max_steps) begin
            step();
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int errs;
        int early;
        logic [NP-1:0] exp_en;

        n_checks   = 0;
        n_pass     = 0;
        rst_sys    = 1'b1;
        sel_valid  = 1'b0;
        sel_port   = '0;
        ctl_scl    = 1'b1;
        ctl_sda    = 1'b1;
        ctl_scl_en = 1'b0;
        ctl_sda_en = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset_ready", sel_ready, 1);
        check("reset_cur_port", cur_port, 0);
        check("reset_switching", switching, 0);
        check("reset_busy", bus_busy, 0);
        check("reset_err", sel_err, 0);
        check("reset_scl_readback", ctl_scl_rb, 1);
        rst_sys = 1'b0;
        step();

        // Same-port request is a one-cycle no-op; out-of-range ports pulse sel_err once
        request(0);
        check("same_ready", sel_ready, 1);
        check("same_switching", switching, 0);
        check("same_cur_port", cur_port, 0);
        check("same_no_err", sel_err, 0);
        request(5);
        check("bad5_err_pulse", sel_err, 1);
        check("bad5_cur_port", cur_port, 0);
        check("bad5_ready", sel_ready, 1);
        step();
        check("bad5_err_once", sel_err, 0);
        request(7);
        check("bad7_err_pulse", sel_err, 1);
        check("bad7_switching", switching, 0);

        // Idle-bus switch 0 -> 2: 2 DRAIN cycles, 16 SETTLE cycles, connected at edge 18
        step();
        ctl_scl_en = 1'b1;
        ctl_sda_en = 1'b1;
        request(2);
        n = 0;
        errs = 0;
        while (!sel_ready && n < 100) begin
            exp_en = (n < 2) ? NP'(1) : '0;
            if (port_scl_en !== exp_en || port_sda_en !== exp_en) errs++;
            if (n == 1 && cur_port !== 0) errs++;
            n++;
            step();
        end
        check("switch_ready_low_cycles", n, SETTLE + 2);
        check("switch_enable_profile", errs, 0);
        check("switch_cur_port", cur_port, 2);
        check("switch_new_enables", port_scl_en, 5'b00100);
        ctl_scl_en = 1'b0;
        ctl_sda_en = 1'b0;

        request(0);
        wait_ready(100, n);
        check("back_to_0_ready", sel_ready, 1);
        check("back_to_0_cur_port", cur_port, 0);

        // START on port 0, request port 1: hold DRAIN until STOP
        ctl_sda_en = 1'b1;
        ctl_sda    = 1'b0;
        repeat (4) step();
        check("drain_start_busy", bus_busy, 1);
        check("drain_sda_readback", ctl_sda_rb, 0);
        ctl_scl_en = 1'b1;
        ctl_scl    = 1'b0;
        repeat (2) step();
        request(1);
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            ctl_scl_en = i[0];
            #1;
            if (port_scl_en !== {4'b0000, ctl_scl_en}) errs++;
            if (sel_ready || !switching) errs++;
            step();
        end
        check("drain_enables_follow", errs, 0);
        ctl_scl_en = 1'b0;
        repeat (3) step();
        check("drain_busy_until_stop", bus_busy, 1);
        check("drain_still_switching", switching, 1);
        ctl_sda_en = 1'b0;
        ctl_scl_en = 1'b1;
        ctl_scl    = 1'b1;
        n = 0;
        early = 0;
        while (!sel_ready && n < 100) begin
            step();
            n++;
            if (!sel_ready && port_scl_en[1]) early++;
        end
        check("stop_to_connect_cycles", n, 20);
        check("no_early_port1_enable", early, 0);
        check("stop_cur_port", cur_port, 1);
        check("stop_port1_enable", port_scl_en, 5'b00010);
        ctl_scl_en = 1'b0;

        // START with no STOP on port 1: idle timeout releases busy, then switch to 2
        step();
        ctl_sda_en = 1'b1;
        ctl_sda    = 1'b0;
        repeat (4) step();
        check("idle_start_busy", bus_busy, 1);
        ctl_scl_en = 1'b1;
        ctl_scl    = 1'b0;
        repeat (2) step();
        ctl_sda_en = 1'b0;
        repeat (3) step();
        request(2);
        repeat (5) step();
        check("idle_drain_waiting", switching, 1);
        ctl_scl_en = 1'b0;
        n = 0;
        while (bus_busy && n < 3000) begin
            step();
            n++;
        end
        check("idle_timeout_cycles", n, IDLE + 2);
        check("idle_still_on_port1", cur_port, 1);
        wait_ready(100, n);
        check("idle_busy_to_connect", n, SETTLE + 1);
        check("idle_cur_port", cur_port, 2);

        // Host holds SDA low with no START: switch waits for the release
        ctl_scl_en = 1'b1;
        ctl_scl    = 1'b0;
        repeat (4) step();
        ctl_sda_en = 1'b1;
        ctl_sda    = 1'b0;
        repeat (4) step();
        ctl_scl_en = 1'b0;
        repeat (4) step();
        check("hold_not_busy", bus_busy, 0);
        request(3);
        errs = 0;
        for (int i = 0; i < 50; i++) begin
            if (sel_ready || !switching) errs++;
            if (port_sda_en !== 5'b00100) errs++;
            if (ctl_sda_rb !== 1'b0) errs++;
            step();
        end
        check("hold_no_switch", errs, 0);
        ctl_sda_en = 1'b0;
        ctl_scl_en = 1'b1;
        ctl_scl    = 1'b1;
        step();
        check("release_settle_enables", port_scl_en, 0);
        check("release_readback_forced", ctl_sda_rb, 1);
        check("release_switching", switching, 1);
        wait_ready(100, n);
        check("release_connect_cycles", n, SETTLE);
        check("release_cur_port", cur_port, 3);
        ctl_scl_en = 1'b0;

        // Reset during SETTLE drops the pending target
        step();
        request(1);
        repeat (4) step();
        check("rst_mid_in_settle", port_scl_en | port_sda_en, 0);
        check("rst_mid_switching", switching, 1);
        rst_sys = 1'b1;
        step();
        check("rst_mid_cur_port", cur_port, 0);
        check("rst_mid_ready", sel_ready, 1);
        check("rst_mid_switching_clr", switching, 0);
        rst_sys = 1'b0;
        repeat (30) step();
        check("rst_target_dropped", cur_port, 0);
        check("rst_idle_after", switching, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
